// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: default timing parameters,
// legal channel-count range and the per-channel event payload.
package btn_pkg;

    localparam int unsigned BTN_CH_MIN        = 2;
    localparam int unsigned BTN_CH_MAX        = 16;
    localparam int unsigned BTN_TICK_DIV      = 1000;
    localparam int unsigned BTN_STABLE        = 8;
    localparam int unsigned BTN_REPEAT_DELAY  = 50;
    localparam int unsigned BTN_REPEAT_PERIOD = 10;

    // Registered per-channel outputs, bundled so the top can fan them out.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
    } btn_evt_t;

endpackage

// File: rtl/btn_channel.sv
// One conditioned button channel: two-flop synchroniser, tick-sampled debounce
// counter and registered press/release pulses. BTN_REPEAT_EN adds auto-repeat.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE        = BTN_STABLE
`ifdef BTN_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = BTN_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = BTN_REPEAT_PERIOD
`endif
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tick,
    input  logic     pb,
    output btn_evt_t evt
);

    localparam int unsigned CNT_W = $clog2(STABLE + 1);

    logic             sync_q;
    logic             pb_s;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             rel_q;

    logic differ_c;
    logic flip_c;
    logic rep_fire_c;

    assign differ_c = (pb_s != level_q);
    assign flip_c   = tick && differ_c && (cnt_q == CNT_W'(STABLE - 1));

`ifdef BTN_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              rep_phase_q;
    logic [HOLD_W-1:0] hold_nxt_c;

    // First repeat after REPEAT_DELAY held ticks, then one every REPEAT_PERIOD.
    always_comb begin
        hold_nxt_c = hold_q + HOLD_W'(1);
        rep_fire_c = tick && level_q && !flip_c &&
                     (hold_nxt_c == (rep_phase_q ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
        end else if (!level_q || flip_c) begin
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
        end else if (tick) begin
            if (rep_fire_c) begin
                hold_q      <= '0;
                rep_phase_q <= 1'b1;
            end else begin
                hold_q <= hold_nxt_c;
            end
        end
    end
`else
    assign rep_fire_c = 1'b0;
`endif

    // Synchroniser, debounce counter and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 1'b0;
            pb_s    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= pb;
            pb_s    <= sync_q;
            press_q <= (flip_c && !level_q) || rep_fire_c;
            rel_q   <= flip_c && level_q;
            if (tick) begin
                if (!differ_c) begin
                    cnt_q <= '0;
                end else if (flip_c) begin
                    level_q <= ~level_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign evt = '{level: level_q, press: press_q, rel: rel_q};

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: shared sample tick, CH debounced
// channels and a lowest-index press encoder. BTN_REPEAT_EN enables auto-repeat.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned CH            = 5,
    parameter int unsigned TICK_DIV      = BTN_TICK_DIV,
    parameter int unsigned STABLE        = BTN_STABLE,
    parameter int unsigned REPEAT_DELAY  = BTN_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = BTN_REPEAT_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         pb,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         press,
    output logic [CH-1:0]         release_pulse,
    output logic                  press_any,
    output logic [$clog2(CH)-1:0] press_idx
);

    localparam int unsigned IDX_W  = $clog2(CH);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Reject illegal configurations at elaboration.
    if (CH < BTN_CH_MIN || CH > BTN_CH_MAX) begin : g_bad_ch
        $error("button_conditioner: CH out of range");
    end
    if (TICK_DIV < 1 || STABLE < 1) begin : g_bad_timing
        $error("button_conditioner: TICK_DIV and STABLE must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick_c;

    assign tick_c = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick_c) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    btn_evt_t evt [CH];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        btn_channel #(
            .STABLE        (STABLE)
`ifdef BTN_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick_c),
            .pb    (pb[i]),
            .evt   (evt[i])
        );

        assign level[i]         = evt[i].level;
        assign press[i]         = evt[i].press;
        assign release_pulse[i] = evt[i].rel;
    end

    // Lowest set press bit wins; scan from the top so lower indices overwrite.
    always_comb begin
        press_idx = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

    assign press_any = |press;

endmodule
